// File: rtl/elastic_connector.sv
// Registered valid/ready stage built on a 2-entry skid buffer: Out, Out_valid,
// Count and the state part of In_ready all come straight from flops.
module elastic_connector #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Flush,
    input  logic [WIDTH-1:0] In,
    input  logic             In_valid,
    output logic             In_ready,
    output logic [WIDTH-1:0] Out,
    output logic             Out_valid,
    input  logic             Out_ready,
    output logic [1:0]       Count
);

    // The encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] m_q;
    logic [WIDTH-1:0] s_q;
    logic             acc;
    logic             drn;
    logic             m_load_in;
    logic             m_load_s;
    logic             s_load_in;

    assign Out_valid = (state != EMPTY);
    assign In_ready  = (state != FULL) & ~Flush;
    assign Out       = m_q;
    assign Count     = state;

    assign acc = In_valid & In_ready;
    assign drn = Out_valid & Out_ready;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path
        // leaves one unassigned; otherwise synthesis infers a latch.
        state_nxt = state;
        m_load_in = 1'b0;
        m_load_s  = 1'b0;
        s_load_in = 1'b0;
        if (Flush) begin
            // In_ready is low, so nothing is accepted; a drain still completes.
            state_nxt = EMPTY;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (acc) begin
                        m_load_in = 1'b1;
                        state_nxt = ONE;
                    end
                end
                ONE: begin
                    if (acc && drn) begin
                        m_load_in = 1'b1;
                    end else if (acc) begin
                        s_load_in = 1'b1;
                        state_nxt = FULL;
                    end else if (drn) begin
                        state_nxt = EMPTY;
                    end
                end
                FULL: begin
                    // The skid word moves up behind the departing main word.
                    if (drn) begin
                        m_load_s  = 1'b1;
                        state_nxt = ONE;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: the data registers are reset too, so Out reads 0 out of reset
    // instead of whatever the flops powered up with.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q <= '0;
            s_q <= '0;
        end else begin
            if (m_load_in) begin
                m_q <= In;
            end else if (m_load_s) begin
                m_q <= s_q;
            end
            if (s_load_in) begin
                s_q <= In;
            end
        end
    end

endmodule

// File: tb/tb_elastic_connector.sv
// Self-checking bench for elastic_connector: a queue-based occupancy model is
// compared every cycle, with directed scenarios pinning literal values.
module tb_elastic_connector;

    localparam int WIDTH = 32;

    logic             clk;
    logic             rst_n;
    logic             Flush;
    logic [WIDTH-1:0] In;
    logic             In_valid;
    logic             In_ready;
    logic [WIDTH-1:0] Out;
    logic             Out_valid;
    logic             Out_ready;
    logic [1:0]       Count;

    int n_checks = 0;
    int n_errors = 0;

    logic [WIDTH-1:0] model_q[$];
    logic [WIDTH-1:0] delivered[$];

    elastic_connector #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .Flush     (Flush),
        .In        (In),
        .In_valid  (In_valid),
        .In_ready  (In_ready),
        .Out       (Out),
        .Out_valid (Out_valid),
        .Out_ready (Out_ready),
        .Count     (Count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // Behavioural model: a FIFO of at most two words, cleared by reset or flush.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_q.delete();
        end else begin
            if (Out_valid && Out_ready) delivered.push_back(Out);
            if (Flush) begin
                model_q.delete();
            end else begin
                automatic bit m_acc = In_valid && (model_q.size() < 2);
                automatic bit m_drn = Out_ready && (model_q.size() > 0);
                if (m_drn) void'(model_q.pop_front());
                if (m_acc) model_q.push_back(In);
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            check("model_out_valid", 32'(Out_valid), 32'(model_q.size() != 0));
            check("model_count", 32'(Count), 32'(model_q.size()));
            check("model_in_ready", 32'(In_ready), 32'((model_q.size() < 2) && !Flush));
            if (model_q.size() != 0) check("model_out", Out, model_q[0]);
        end
    end

    // Apply one cycle of inputs; returns 2 time units after the edge.
    task automatic drive(input logic v, input logic [31:0] d, input logic ordy, input logic fl);
        In_valid  = v;
        In        = d;
        Out_ready = ordy;
        Flush     = fl;
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n     = 1'b0;
        Flush     = 1'b0;
        In        = 32'hDEAD_BEEF;
        In_valid  = 1'b1;
        Out_ready = 1'b0;

        // Reset with a word offered: nothing gets in.
        repeat (3) @(posedge clk);
        #2;
        check("reset_out_valid", 32'(Out_valid), 32'd0);
        check("reset_count", 32'(Count), 32'd0);
        check("reset_out", Out, 32'd0);
        In_valid = 1'b0;
        rst_n    = 1'b1;
        #1;
        check("reset_in_ready", 32'(In_ready), 32'd1);
        @(posedge clk);
        #2;

        // Streaming 1..8 with Out_ready high.
        delivered.delete();
        for (int k = 1; k <= 8; k++) begin
            drive(1'b1, 32'(k), 1'b1, 1'b0);
            check("stream_out", Out, 32'(k));
            check("stream_in_ready", 32'(In_ready), 32'd1);
            check("stream_count_le1", 32'(Count <= 2'd1), 32'd1);
        end
        drive(1'b0, 32'd0, 1'b1, 1'b0);
        check("stream_delivered_n", 32'(delivered.size()), 32'd8);
        for (int k = 0; k < 8 && k < delivered.size(); k++)
            check("stream_order", delivered[k], 32'(k + 1));
        check("stream_empty", 32'(Out_valid), 32'd0);

        // Backpressure: A and B are taken, C waits upstream.
        drive(1'b1, 32'hA, 1'b0, 1'b0);
        check("bp_count1", 32'(Count), 32'd1);
        drive(1'b1, 32'hB, 1'b0, 1'b0);
        check("bp_count2", 32'(Count), 32'd2);
        check("bp_in_ready", 32'(In_ready), 32'd0);
        drive(1'b1, 32'hC, 1'b0, 1'b0);
        check("bp_hold_count", 32'(Count), 32'd2);
        check("bp_stall_out", Out, 32'hA);
        delivered.delete();
        drive(1'b1, 32'hC, 1'b1, 1'b0);
        check("bp_out_b", Out, 32'hB);
        check("bp_count_after_drain", 32'(Count), 32'd1);
        drive(1'b1, 32'hC, 1'b1, 1'b0);
        check("bp_out_c", Out, 32'hC);
        drive(1'b0, 32'd0, 1'b1, 1'b0);
        check("bp_delivered_n", 32'(delivered.size()), 32'd3);
        if (delivered.size() == 3) begin
            check("bp_d0", delivered[0], 32'hA);
            check("bp_d1", delivered[1], 32'hB);
            check("bp_d2", delivered[2], 32'hC);
        end

        // Accept and drain together while holding one word.
        drive(1'b1, 32'h5, 1'b0, 1'b0);
        check("sim_m5", Out, 32'h5);
        drive(1'b1, 32'h6, 1'b1, 1'b0);
        check("sim_out6", Out, 32'h6);
        check("sim_count1", 32'(Count), 32'd1);
        drive(1'b0, 32'd0, 1'b1, 1'b0);

        // Flush while FULL with a word offered.
        drive(1'b1, 32'h11, 1'b0, 1'b0);
        drive(1'b1, 32'h22, 1'b0, 1'b0);
        check("flush_pre_count", 32'(Count), 32'd2);
        In_valid  = 1'b1;
        In        = 32'h33;
        Flush     = 1'b1;
        Out_ready = 1'b0;
        #1;
        check("flush_in_ready", 32'(In_ready), 32'd0);
        @(posedge clk);
        #2;
        check("flush_count", 32'(Count), 32'd0);
        check("flush_out_valid", 32'(Out_valid), 32'd0);
        drive(1'b0, 32'd0, 1'b1, 1'b0);
        check("flush_no_0x33", 32'(Out_valid), 32'd0);

        // Flush in ONE with a concurrent drain.
        drive(1'b1, 32'h77, 1'b0, 1'b0);
        drive(1'b1, 32'h88, 1'b1, 1'b1);
        check("flush_one_count", 32'(Count), 32'd0);

        // Asynchronous reset while FULL.
        drive(1'b1, 32'h44, 1'b0, 1'b0);
        drive(1'b1, 32'h55, 1'b0, 1'b0);
        check("areset_pre_count", 32'(Count), 32'd2);
        In_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("areset_out_valid", 32'(Out_valid), 32'd0);
        check("areset_count", 32'(Count), 32'd0);
        check("areset_out", Out, 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #2;

        // Short mixed tail for the per-cycle model comparison.
        for (int k = 0; k < 40; k++)
            drive(1'(k % 3 != 0), 32'h100 + 32'(k), 1'(k % 4 < 2), 1'(k == 27));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
